// File: rtl/sign_narrow_if.sv
// Handshake bundle for sign_narrow: the input stream, the narrowed output stream,
// and the overflow counter controls.
interface sign_narrow_if #(
    parameter int N = 12
);
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  dataIn;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] dataOut;
    logic         ovf;
    logic         clear_count;
    logic [7:0]   ovf_count;

    modport master (
        output in_valid,
        input  in_ready,
        output dataIn,
        input  out_valid,
        output out_ready,
        input  dataOut,
        input  ovf,
        output clear_count,
        input  ovf_count
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  dataIn,
        output out_valid,
        input  out_ready,
        output dataOut,
        output ovf,
        input  clear_count,
        output ovf_count
    );
endinterface

// File: rtl/sign_narrow.sv
// Narrows 16-bit signed values to N bits, flags and counts values that do not fit, and buffers results in a 2-entry queue.
// Define SIGN_NARROW_SAT_EN to saturate out-of-range values; otherwise they wrap to the low N bits.
module sign_narrow #(
    parameter int N = 12
) (
    input  logic          clk,
    input  logic          rst,
    sign_narrow_if.slave  bus
);
    localparam logic [15:0]  HI_MASK = 16'hFFFF << (N - 1);
    localparam logic [N-1:0] SAT_POS = {1'b0, {(N - 1){1'b1}}};
    localparam logic [N-1:0] SAT_NEG = {1'b1, {(N - 1){1'b0}}};

    logic [15:0]  hi_bits;
    logic         fits;
    logic [N-1:0] narrow_val;
    logic         push;
    logic         pop;

    logic [N-1:0] q_val [2];
    logic         q_ovf [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    // A value fits when bits [15:N-1] are all copies of the sign bit.
    always_comb begin
        hi_bits    = bus.dataIn & HI_MASK;
        fits       = (hi_bits == 16'h0000) || (hi_bits == HI_MASK);
        narrow_val = bus.dataIn[N-1:0];
`ifdef SIGN_NARROW_SAT_EN
        if (!fits) begin
            narrow_val = bus.dataIn[15] ? SAT_NEG : SAT_POS;
        end
`endif
    end

    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.dataOut   = q_val[rd_ptr];
    assign bus.ovf       = q_ovf[rd_ptr];

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                q_val[i] <= '0;
                q_ovf[i] <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                q_val[wr_ptr] <= narrow_val;
                q_ovf[wr_ptr] <= !fits;
                wr_ptr        <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Clear wins over the increment, but a same-cycle overflowing accept still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ovf_count <= 8'd0;
        end else if (bus.clear_count) begin
            bus.ovf_count <= (push && !fits) ? 8'd1 : 8'd0;
        end else if (push && !fits && (bus.ovf_count != 8'd255)) begin
            bus.ovf_count <= bus.ovf_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_sign_narrow.sv
// Directed self-checking bench for sign_narrow with N = 12, covering both the wrap and saturate builds.
module tb_sign_narrow;
    localparam int N = 12;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sign_narrow_if #(.N(N)) bus ();

    sign_narrow #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs are changed and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.dataIn = 16'h0000;
        bus.out_ready = 1'b0;
        bus.clear_count = 1'b0;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++;
        if (bus.dataOut !== 12'h000 || bus.ovf !== 1'b0) begin
            errors++; $display("FAIL reset_data got %h/%b want 000/0", bus.dataOut, bus.ovf);
        end
        checks++;
        if (bus.ovf_count !== 8'd0) begin errors++; $display("FAIL reset_ovf_count got %0d want 0", bus.ovf_count); end
    endtask

    task automatic test_fit();
        logic [15:0] vin  [2];
        logic [11:0] vexp [2];
        vin[0] = 16'h0001; vexp[0] = 12'h001;
        vin[1] = 16'hF800; vexp[1] = 12'h800;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.dataIn = vin[i];
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.dataOut !== vexp[i] || bus.ovf !== 1'b0) begin
                errors++;
                $display("FAIL fit_%0d got v=%b d=%h o=%b want v=1 d=%h o=0", i, bus.out_valid, bus.dataOut, bus.ovf, vexp[i]);
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ovf_count !== 8'd0) begin
            errors++; $display("FAIL fit_drain got v=%b cnt=%0d want v=0 cnt=0", bus.out_valid, bus.ovf_count);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] vin  [2];
        logic [11:0] vexp [2];
        vin[0] = 16'h0800;
        vin[1] = 16'h8000;
`ifdef SIGN_NARROW_SAT_EN
        vexp[0] = 12'h7FF; vexp[1] = 12'h800;
`else
        vexp[0] = 12'h800; vexp[1] = 12'h000;
`endif
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.dataIn = vin[i];
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.dataOut !== vexp[i] || bus.ovf !== 1'b1) begin
                errors++;
                $display("FAIL ovf_%0d got v=%b d=%h o=%b want v=1 d=%h o=1", i, bus.out_valid, bus.dataOut, bus.ovf, vexp[i]);
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.ovf_count !== 8'd2) begin errors++; $display("FAIL ovf_count got %0d want 2", bus.ovf_count); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.dataIn = 16'h0123;
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.dataOut !== 12'h123) begin
            errors++; $display("FAIL bp_first got r=%b d=%h want r=1 d=123", bus.in_ready, bus.dataOut);
        end
        bus.dataIn = 16'hFF00;
        step();
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got in_ready=%b want 0", bus.in_ready); end
        bus.dataIn = 16'h0456;
        step();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.dataOut !== 12'h123 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold got r=%b v=%b d=%h want r=0 v=1 d=123", bus.in_ready, bus.out_valid, bus.dataOut);
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.dataOut !== 12'hF00) begin
            errors++; $display("FAIL bp_second got r=%b d=%h want r=1 d=f00", bus.in_ready, bus.dataOut);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.dataOut !== 12'h456) begin
            errors++; $display("FAIL bp_third got v=%b d=%h want v=1 d=456", bus.out_valid, bus.dataOut);
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ovf_count !== 8'd2) begin
            errors++; $display("FAIL bp_drain got v=%b cnt=%0d want v=0 cnt=2", bus.out_valid, bus.ovf_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v = 16'(i * 37 + 5);
            bus.in_valid = 1'b1;
            bus.dataIn = v;
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.dataOut !== v[11:0]) begin
                errors++;
                $display("FAIL b2b_%0d got v=%b r=%b d=%h want v=1 r=1 d=%h", i, bus.out_valid, bus.in_ready, bus.dataOut, v[11:0]);
            end
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_count_saturate();
        bus.out_ready = 1'b1;
        bus.clear_count = 1'b1;
        step();
        bus.clear_count = 1'b0;
        checks++;
        if (bus.ovf_count !== 8'd0) begin errors++; $display("FAIL clear_only got %0d want 0", bus.ovf_count); end
        bus.in_valid = 1'b1;
        bus.dataIn = 16'h4000;
        for (int i = 0; i < 255; i++) step();
        checks++;
        if (bus.ovf_count !== 8'd255) begin errors++; $display("FAIL count_255 got %0d want 255", bus.ovf_count); end
        step();
        step();
        checks++;
        if (bus.ovf_count !== 8'd255) begin errors++; $display("FAIL count_hold got %0d want 255", bus.ovf_count); end
        bus.clear_count = 1'b1;
        step();
        checks++;
        if (bus.ovf_count !== 8'd1) begin errors++; $display("FAIL clear_with_ovf got %0d want 1", bus.ovf_count); end
        bus.dataIn = 16'h0010;
        step();
        checks++;
        if (bus.ovf_count !== 8'd0) begin errors++; $display("FAIL clear_with_fit got %0d want 0", bus.ovf_count); end
        bus.clear_count = 1'b0;
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.dataIn = 16'h7000;
        step();
        bus.dataIn = 16'h9000;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.ovf_count !== 8'd2) begin
            errors++; $display("FAIL mid_full got r=%b cnt=%0d want r=0 cnt=2", bus.in_ready, bus.ovf_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.ovf_count !== 8'd0 || bus.dataOut !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset got v=%b r=%b cnt=%0d d=%h want v=0 r=1 cnt=0 d=000",
                     bus.out_valid, bus.in_ready, bus.ovf_count, bus.dataOut);
        end
    endtask

    task automatic test_round_trip();
        logic [15:0] vin [6];
        logic [15:0] ext;
        vin[0] = 16'h07FF; vin[1] = 16'hF800; vin[2] = 16'h0000;
        vin[3] = 16'hFFFF; vin[4] = 16'h0555; vin[5] = 16'hFABC;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.dataIn = vin[i];
            step();
            ext = {{(16 - N){bus.dataOut[N-1]}}, bus.dataOut};
            checks++;
            if (bus.out_valid !== 1'b1 || bus.ovf !== 1'b0 || ext !== vin[i]) begin
                errors++;
                $display("FAIL round_trip_%0d got v=%b o=%b ext=%h want v=1 o=0 ext=%h", i, bus.out_valid, bus.ovf, ext, vin[i]);
            end
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fit();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_count_saturate();
        test_reset_mid();
        test_round_trip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
